// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - sequences the shared multi-cycle multiply/divide unit
// Latches a mult/div from execute, starts the unit, stalls until ready or watchdog, then writes back once.
module multdiv_sequencer #(
  parameter int TIMEOUT   = 40,
  parameter int MULT_CODE = 4,
  parameter int DIV_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_mult,
  input  logic        x_div,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_opA,
  input  logic [31:0] x_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITEBACK} state_t;

  state_t      state, state_nxt;
  logic        op;          // 0 = mult, 1 = div
  logic [4:0]  rd;
  logic [5:0]  cnt;
  logic [31:0] result;
  logic        exc;
  logic        issue;
  logic        timeout_hit;

  assign issue       = x_mult | x_div;
  assign timeout_hit = (cnt == 6'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      op     <= 1'b0;
      rd     <= 5'd0;
      cnt    <= 6'd0;
      result <= 32'd0;
      exc    <= 1'b0;
      md_opA <= 32'd0;
      md_opB <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (issue) begin
            op     <= ~x_mult;  // mult wins when both flags are set
            rd     <= x_rd;
            md_opA <= x_opA;
            md_opB <= x_opB;
            result <= 32'd0;
            exc    <= 1'b0;
          end
        end
        START: cnt <= 6'd0;
        WAIT: begin
          cnt <= cnt + 6'd1;
          if (md_ready) begin
            result <= md_result;
            exc    <= md_exception;
          end else if (timeout_hit) begin
            exc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = START;
          stall     = ~reset;  // outputs stay quiet while reset is held
        end
      end
      START: begin
        state_nxt    = WAIT;
        stall        = 1'b1;
        md_ctrl_mult = ~op;
        md_ctrl_div  = op;
      end
      WAIT: begin
        stall = 1'b1;
        if (md_ready || timeout_hit) state_nxt = WRITEBACK;
      end
      WRITEBACK: begin
        state_nxt = IDLE;
        if (exc) begin
          wb_valid = 1'b1;
          wb_rd    = 5'd30;
          wb_data  = op ? 32'(DIV_CODE) : 32'(MULT_CODE);
        end else if (rd != 5'd0) begin
          wb_valid = 1'b1;
          wb_rd    = rd;
          wb_data  = result;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
